// File: rtl/ctrl_escala_datapath.sv
// ---------------------------------------------------------------------------
// ctrl_escala_datapath
//
// Sequencing controller for the pixel-scaling datapath. Walks the source
// image in raster order, presents each ROM address, strobes the datapath,
// and hands every output pixel to the VGA side with a valid/ready handshake.
// Supported modes: 00 decimation, 01 2x2 average, 10 2x replication.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle command strobe, accepted only when idle
//   opcode[1:0]    operation mode, latched on an accepted start (11 = error)
//   saida_pronta   downstream ready for the current output pixel
//   rom_addr       source pixel address, lin*LARGURA+col
//   entrada_valida ROM data valid this cycle (datapath write/shift)
//   enable_cnt     advance datapath x/y counters
//   captura_pixel  load replication register instead of the window
//   selec_mux[1:0] datapath output select (latched mode)
//   saida_valida   output pixel valid toward VGA
//   busy           controller is running a frame
//   done           one-cycle pulse at end of frame
//   erro           one-cycle pulse on start with the reserved opcode
// ---------------------------------------------------------------------------
module ctrl_escala_datapath #(
    parameter int LARGURA = 320,
    parameter int ALTURA  = 240,
    parameter int ADDR_W  = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic              saida_pronta,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              entrada_valida,
    output logic              enable_cnt,
    output logic              captura_pixel,
    output logic [1:0]        selec_mux,
    output logic              saida_valida,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam int LW = (ALTURA  > 1) ? $clog2(ALTURA)  : 1;

    localparam logic [CW-1:0]     COL_MAX  = CW'(LARGURA - 1);
    localparam logic [LW-1:0]     LIN_MAX  = LW'(ALTURA - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(LARGURA);

    localparam logic [1:0] MODO_DEC = 2'b00;
    localparam logic [1:0] MODO_MED = 2'b01;
    localparam logic [1:0] MODO_REP = 2'b10;
    localparam logic [1:0] MODO_RES = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LE,
        DADO,
        EMITE,
        EMITE2,
        AVANCA,
        FIM
    } state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [LW-1:0]     lin;
    logic              pass;      // replication: 0 = first read of row, 1 = re-read
    logic [1:0]        modo;
    logic [ADDR_W-1:0] row_base;  // lin*LARGURA kept incrementally, no multiplier
    logic              emite;

    // The selector follows the latched mode for the whole frame.
    assign selec_mux = modo;

    // Emit decision for the pixel currently in DADO. In average mode the
    // window is complete only at the odd/odd corner of each 2x2 block.
    always_comb begin
        emite = 1'b0;
        case (modo)
            MODO_DEC: emite = ~col[0] & ~lin[0];
            MODO_MED: emite =  col[0] &  lin[0];
            default:  emite = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            lin            <= '0;
            pass           <= 1'b0;
            modo           <= MODO_DEC;
            row_base       <= '0;
            rom_addr       <= '0;
            entrada_valida <= 1'b0;
            enable_cnt     <= 1'b0;
            captura_pixel  <= 1'b0;
            saida_valida   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            erro           <= 1'b0;
        end else begin
            // Single-cycle strobes default low; they are raised on entry
            // into the state in which they must be visible.
            entrada_valida <= 1'b0;
            enable_cnt     <= 1'b0;
            captura_pixel  <= 1'b0;
            done           <= 1'b0;
            erro           <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (opcode == MODO_RES) begin
                            erro <= 1'b1;
                        end else begin
                            modo     <= opcode;
                            col      <= '0;
                            lin      <= '0;
                            pass     <= 1'b0;
                            row_base <= '0;
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= LE;
                        end
                    end
                end

                // Address is already on rom_addr; ROM data arrives next cycle.
                LE: begin
                    entrada_valida <= 1'b1;
                    // Second pass of a replicated row must not advance the
                    // datapath counters, so the frame sees exactly one pulse
                    // per source pixel.
                    enable_cnt     <= !((modo == MODO_REP) && pass);
                    captura_pixel  <= (modo == MODO_REP);
                    state          <= DADO;
                end

                DADO: begin
                    if (emite) begin
                        saida_valida <= 1'b1;
                        state        <= EMITE;
                    end else begin
                        state <= AVANCA;
                    end
                end

                EMITE: begin
                    if (saida_pronta) begin
                        if (modo == MODO_REP) begin
                            // valid stays high for the duplicate pixel
                            state <= EMITE2;
                        end else begin
                            saida_valida <= 1'b0;
                            state        <= AVANCA;
                        end
                    end
                end

                EMITE2: begin
                    if (saida_pronta) begin
                        saida_valida <= 1'b0;
                        state        <= AVANCA;
                    end
                end

                AVANCA: begin
                    if (col != COL_MAX) begin
                        col      <= col + 1'b1;
                        rom_addr <= rom_addr + 1'b1;
                        state    <= LE;
                    end else begin
                        col <= '0;
                        if ((modo == MODO_REP) && !pass) begin
                            // re-read the same row for the vertical copy
                            pass     <= 1'b1;
                            rom_addr <= row_base;
                            state    <= LE;
                        end else begin
                            pass <= 1'b0;
                            if (lin == LIN_MAX) begin
                                done  <= 1'b1;
                                state <= FIM;
                            end else begin
                                lin      <= lin + 1'b1;
                                row_base <= row_base + ROW_STEP;
                                rom_addr <= row_base + ROW_STEP;
                                state    <= LE;
                            end
                        end
                    end
                end

                FIM: begin
                    busy     <= 1'b0;
                    rom_addr <= '0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_escala_datapath.sv
// ---------------------------------------------------------------------------
// tb_ctrl_escala_datapath
//
// Scoreboard bench for ctrl_escala_datapath on a reduced 16x8 image.
// Each frame pushes its expected (address, selector) sequence into a queue;
// an independent monitor pops one entry per handshake transfer.
// ---------------------------------------------------------------------------
module tb_ctrl_escala_datapath;

    localparam int L  = 16;
    localparam int A  = 8;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    opcode;
    logic          saida_pronta = 1'b1;
    logic [AW-1:0] rom_addr;
    logic          entrada_valida;
    logic          enable_cnt;
    logic          captura_pixel;
    logic [1:0]    selec_mux;
    logic          saida_valida;
    logic          busy;
    logic          done;
    logic          erro;

    ctrl_escala_datapath #(.LARGURA(L), .ALTURA(A), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .opcode        (opcode),
        .saida_pronta  (saida_pronta),
        .rom_addr      (rom_addr),
        .entrada_valida(entrada_valida),
        .enable_cnt    (enable_cnt),
        .captura_pixel (captura_pixel),
        .selec_mux     (selec_mux),
        .saida_valida  (saida_valida),
        .busy          (busy),
        .done          (done),
        .erro          (erro)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int exp_addr[$];
    int exp_sel[$];
    int xfer_cnt   = 0;
    int en_cnt     = 0;
    int done_cnt   = 0;
    int stall_at   = -1;
    int stall_left = 0;
    int stall_seen = 0;
    bit stall_used = 0;
    bit stall_prev = 0;
    bit busy_fall  = 0;
    int stall_addr = 0;
    int first_addr [4];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Ready driver: normally ready, optionally withheld for 10 cycles when
    // the selected output is first presented.
    always @(posedge clk) begin
        #1;
        if (stall_at >= 0 && !stall_used && saida_valida && xfer_cnt == stall_at) begin
            stall_left = 10;
            stall_used = 1;
        end
        if (stall_left > 0) begin
            saida_pronta = 1'b0;
            stall_left--;
        end else begin
            saida_pronta = 1'b1;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            logic excl;
            excl = (entrada_valida & saida_valida) | (entrada_valida & done) | (saida_valida & done);
            chk("strobe_excl", 64'(excl), 64'd0);
            if (enable_cnt) en_cnt++;
            if (done) begin
                done_cnt++;
                chk("busy_with_done", 64'(busy), 64'd1);
                busy_fall = 1;
            end else if (busy_fall) begin
                busy_fall = 0;
                chk("busy_fall_after_done", 64'(busy), 64'd0);
            end
            if (stall_prev) begin
                stall_seen++;
                chk("stall_valid_hold", 64'(saida_valida), 64'd1);
                chk("stall_addr_hold", 64'(rom_addr), 64'(stall_addr));
                chk("stall_no_read", 64'(entrada_valida), 64'd0);
            end
            stall_prev = saida_valida && !saida_pronta;
            stall_addr = int'(rom_addr);
            if (saida_valida && saida_pronta) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_output", 64'(rom_addr), 64'hFFFF);
                end else begin
                    int ea, es;
                    ea = exp_addr.pop_front();
                    es = exp_sel.pop_front();
                    chk("out_addr", 64'(rom_addr), 64'(ea));
                    chk("out_sel", 64'(selec_mux), 64'(es));
                end
                if (xfer_cnt < 4) first_addr[xfer_cnt] = int'(rom_addr);
                xfer_cnt++;
            end
        end
    end

    task automatic build_expected(input logic [1:0] op);
        exp_addr.delete();
        exp_sel.delete();
        if (op == 2'b00) begin
            for (int y = 0; y < A; y += 2)
                for (int x = 0; x < L; x += 2) begin
                    exp_addr.push_back(y * L + x); exp_sel.push_back(0);
                end
        end else if (op == 2'b01) begin
            for (int y = 1; y < A; y += 2)
                for (int x = 1; x < L; x += 2) begin
                    exp_addr.push_back(y * L + x); exp_sel.push_back(1);
                end
        end else begin
            for (int y = 0; y < A; y++)
                for (int p = 0; p < 2; p++)
                    for (int x = 0; x < L; x++)
                        for (int k = 0; k < 2; k++) begin
                            exp_addr.push_back(y * L + x); exp_sel.push_back(2);
                        end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk(name, 64'({rom_addr, entrada_valida, enable_cnt, captura_pixel, selec_mux,
                       saida_valida, busy, done, erro}), 64'd0);
    endtask

    task automatic run_frame(input logic [1:0] op, input int stall_i, input bit inject,
                             input int reset_at);
        int n_exp;
        bit aborted = 0;
        bit got_done = 0;
        build_expected(op);
        n_exp = exp_addr.size();
        xfer_cnt = 0; en_cnt = 0; done_cnt = 0; stall_seen = 0;
        stall_used = 0; stall_at = stall_i;
        @(posedge clk); #1 start = 1'b1; opcode = op;
        @(posedge clk); #1 start = 1'b0; opcode = 2'b00;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int c = 0; c < 5000; c++) begin
            if (done_cnt != 0) begin got_done = 1; break; end
            if (reset_at >= 0 && xfer_cnt >= reset_at) begin aborted = 1; break; end
            if (inject && c == 30) begin start = 1'b1; opcode = 2'b10; end
            else if (inject && c == 31) begin start = 1'b0; opcode = 2'b00; end
            @(posedge clk); #1;
        end
        if (aborted) begin
            #2 rst = 1'b1;
            #1 check_idle_outputs("midframe_reset_outputs");
            exp_addr.delete(); exp_sel.delete();
            stall_prev = 0; busy_fall = 0;
            repeat (2) @(posedge clk);
            #3 rst = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("no_done_after_reset", 64'(done_cnt), 64'd0);
            chk("idle_after_reset", 64'(busy), 64'd0);
        end else begin
            chk("frame_done_seen", 64'(got_done), 64'd1);
            repeat (3) @(posedge clk);
            #1;
            chk("done_pulses", 64'(done_cnt), 64'd1);
            chk("output_count", 64'(xfer_cnt), 64'(n_exp));
            chk("enable_cnt_pulses", 64'(en_cnt), 64'(L * A));
            chk("expected_left", 64'(exp_addr.size()), 64'd0);
            if (stall_i >= 0) chk("stall_cycles", 64'(stall_seen), 64'd10);
        end
        stall_at = -1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = 2'b00;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset_state");
        rst = 1'b0;

        // reserved opcode: error pulse, stays idle
        @(posedge clk); #1 start = 1'b1; opcode = 2'b11;
        @(posedge clk); #1 start = 1'b0; opcode = 2'b00;
        chk("erro_pulse", 64'(erro), 64'd1);
        chk("erro_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("erro_one_cycle", 64'(erro), 64'd0);
        chk("erro_still_idle", 64'(busy), 64'd0);

        // decimation
        run_frame(2'b00, -1, 0, -1);
        chk("dec_first0", 64'(first_addr[0]), 64'd0);
        chk("dec_first1", 64'(first_addr[1]), 64'd2);
        chk("dec_first2", 64'(first_addr[2]), 64'd4);

        // 2x2 average: first output at x=1,y=1
        run_frame(2'b01, -1, 0, -1);
        chk("avg_first", 64'(first_addr[0]), 64'(L + 1));

        // replication: each address twice
        run_frame(2'b10, -1, 0, -1);
        chk("rep_first0", 64'(first_addr[0]), 64'd0);
        chk("rep_first1", 64'(first_addr[1]), 64'd0);
        chk("rep_first2", 64'(first_addr[2]), 64'd1);
        chk("rep_first3", 64'(first_addr[3]), 64'd1);

        // decimation with back-pressure on 5th output and a start while busy
        run_frame(2'b00, 4, 1, -1);

        // mid-frame reset in average mode, then a full frame
        run_frame(2'b01, -1, 0, 20);
        run_frame(2'b01, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
